// File: rtl/vmx_acc_drain.sv
// Accumulates PE-column partial sums across K-tiles and buffers results in a small FIFO.
// Optional build macro VMX_DRAIN_SAT_EN: saturate accumulation at all-ones instead of wrapping.
module vmx_acc_drain #(
   parameter int SUM_W      = 32,
   parameter int ACC_W      = 48,
   parameter int FIFO_DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [SUM_W-1:0] in_sum,
   input  logic             in_simd,
   input  logic             in_first,
   input  logic             in_last,
   output logic             in_ready,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_data,
   output logic             out_simd,
   output logic [7:0]       beat_cnt,
   output logic [1:0]       err
);

   localparam int SL_W  = SUM_W / 2;
   localparam int AL_W  = ACC_W / 2;
   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic {IDLE, ACCUM} state_t;

   state_t               state;
   logic [ACC_W-1:0]     acc_p1;
   logic                 mode_p1;
   logic [ACC_W:0]       mem [FIFO_DEPTH];
   logic [PTR_W-1:0]     wr_ptr;
   logic [PTR_W-1:0]     rd_ptr;
   logic [CNT_W-1:0]     count;

   logic                 restart;
   logic                 accept;
   logic                 mode_use;
   logic [ACC_W-1:0]     acc_base;
   logic [ACC_W-1:0]     acc_nxt;
   logic                 push;
   logic                 pop;
   logic                 full;
   logic                 wr_en;
   logic                 proto_err;

   function automatic logic [AL_W-1:0] add_lane(input logic [AL_W-1:0] a, input logic [AL_W-1:0] b);
      logic [AL_W:0] s;
      s = {1'b0, a} + {1'b0, b};
`ifdef VMX_DRAIN_SAT_EN
      if (s[AL_W]) return '1;
`endif
      return s[AL_W-1:0];
   endfunction

   function automatic logic [ACC_W-1:0] add_full(input logic [ACC_W-1:0] a, input logic [ACC_W-1:0] b);
      logic [ACC_W:0] s;
      s = {1'b0, a} + {1'b0, b};
`ifdef VMX_DRAIN_SAT_EN
      if (s[ACC_W]) return '1;
`endif
      return s[ACC_W-1:0];
   endfunction

   // Lanes are independent in SIMD mode: no carry crosses the AL_W boundary.
   function automatic logic [ACC_W-1:0] accumulate(input logic [ACC_W-1:0] a,
                                                   input logic [SUM_W-1:0] sum,
                                                   input logic             simd);
      logic [ACC_W-1:0] r;
      if (simd) begin
         r[AL_W-1:0]     = add_lane(a[AL_W-1:0],     AL_W'(sum[SL_W-1:0]));
         r[ACC_W-1:AL_W] = add_lane(a[ACC_W-1:AL_W], AL_W'(sum[SUM_W-1:SL_W]));
      end else begin
         r = add_full(a, ACC_W'(sum));
      end
      return r;
   endfunction

   // Stage p0: a first beat always opens a new group, even mid-group.
   always_comb begin
      restart   = in_valid & in_first;
      accept    = in_valid & ((state == ACCUM) | in_first);
      mode_use  = restart ? in_simd : mode_p1;
      acc_base  = restart ? '0 : acc_p1;
      acc_nxt   = accumulate(acc_base, in_sum, mode_use);
      push      = accept & in_last;
      pop       = out_valid & out_ready;
      full      = (count == CNT_W'(FIFO_DEPTH));
      wr_en     = push & (!full | pop);
      proto_err = in_valid & (((state == IDLE) & !in_first) |
                              ((state == ACCUM) & in_first) |
                              ((state == ACCUM) & !in_first & (in_simd != mode_p1)));
   end

   assign out_valid = (count != '0);
   assign in_ready  = !full | pop;
   assign out_data  = out_valid ? mem[rd_ptr][ACC_W-1:0] : '0;
   assign out_simd  = out_valid ? mem[rd_ptr][ACC_W] : 1'b0;

   // Stage p1: accumulator, group FSM, FIFO pointers and sticky errors.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         acc_p1   <= '0;
         mode_p1  <= 1'b0;
         beat_cnt <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         err      <= '0;
      end else begin
         if (accept) begin
            acc_p1  <= acc_nxt;
            mode_p1 <= mode_use;
            state   <= in_last ? IDLE : ACCUM;
            if (restart)
               beat_cnt <= 8'd1;
            else if (beat_cnt != 8'hFF)
               beat_cnt <= beat_cnt + 8'd1;
         end
         if (proto_err)
            err[0] <= 1'b1;
         if (push & full & !pop)
            err[1] <= 1'b1;
         if (wr_en)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({wr_en, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_ptr] <= {mode_use, acc_nxt};
   end

endmodule

// File: tb/tb_vmx_acc_drain.sv
// Directed bench for vmx_acc_drain: hand-computed results for each scenario.
module tb_vmx_acc_drain;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [31:0] in_sum;
   logic        in_simd;
   logic        in_first;
   logic        in_last;
   logic        in_ready;
   logic        out_valid;
   logic        out_ready;
   logic [47:0] out_data;
   logic        out_simd;
   logic [7:0]  beat_cnt;
   logic [1:0]  err;

   int n_vec = 0;
   int n_bad = 0;

   vmx_acc_drain dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_sum    (in_sum),
      .in_simd   (in_simd),
      .in_first  (in_first),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_simd  (out_simd),
      .beat_cnt  (beat_cnt),
      .err       (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic drive(input logic [31:0] s, input logic simd, input logic first, input logic last);
      in_valid = 1'b1;
      in_sum   = s;
      in_simd  = simd;
      in_first = first;
      in_last  = last;
   endtask

   task automatic idle();
      in_valid = 1'b0;
      in_sum   = '0;
      in_simd  = 1'b0;
      in_first = 1'b0;
      in_last  = 1'b0;
   endtask

   logic [47:0] exp5;

   initial begin
      rst = 1'b1;
      out_ready = 1'b1;
      idle();
      tick(); tick();
      rst = 1'b0;
      tick();
      chk("rst_valid", out_valid, 0);
      chk("rst_data",  out_data,  0);
      chk("rst_simd",  out_simd,  0);
      chk("rst_bcnt",  beat_cnt,  0);
      chk("rst_err",   err,       0);
      chk("rst_ready", in_ready,  1);

      // Mode 0 three-beat group
      drive(100, 0, 1, 0); tick();
      drive(200, 0, 0, 0); tick();
      drive(300, 0, 0, 1); tick();
      idle();
      chk("m0_valid", out_valid, 1);
      chk("m0_data",  out_data,  600);
      chk("m0_simd",  out_simd,  0);
      chk("m0_bcnt",  beat_cnt,  3);
      tick();
      chk("m0_popped", out_valid, 0);

      // SIMD two-beat group
      drive(32'h0003_0005, 1, 1, 0); tick();
      chk("simd_bcnt1", beat_cnt, 1);
      drive(32'h0003_0005, 1, 0, 1); tick();
      idle();
      chk("simd_bcnt2", beat_cnt, 2);
      chk("simd_valid", out_valid, 1);
      chk("simd_data",  out_data,  48'h000006_00000A);
      chk("simd_simd",  out_simd,  1);
      tick();

      // Single-beat group, full-width all-ones
      drive(32'hFFFF_FFFF, 0, 1, 1); tick();
      idle();
      chk("one_data",  out_data, 48'h0000_FFFF_FFFF);
      chk("one_bcnt",  beat_cnt, 1);
      tick();
      chk("one_popped", out_valid, 0);

      // Fill FIFO with consumer stalled; fifth result overflows
      out_ready = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         drive(k, 0, 1, 1);
         if (k == 5) begin
            #1;
            chk("full_ready", in_ready, 0);
         end
         tick();
      end
      idle();
      chk("ovf_err",   err,      2'b10);
      chk("ovf_ready", in_ready, 0);
      chk("ovf_head",  out_data, 1);
      tick();
      chk("hold_data", out_data, 1);
      out_ready = 1'b1;
      #1;
      chk("pop_ready", in_ready, 1);
      for (int k = 1; k <= 4; k++) begin
         chk("drain_valid", out_valid, 1);
         chk("drain_data",  out_data,  k);
         tick();
      end
      chk("drain_empty", out_valid, 0);
      chk("drain_ready", in_ready,  1);

      // Lane-0 boundary: 0xFFFFFF + 1 with lane 1 counting beats
      drive(32'h0001_FFFF, 1, 1, 0); tick();
      for (int i = 0; i < 255; i++) begin
         drive(32'h0001_FFFF, 1, 0, 0); tick();
      end
      drive(32'h0001_00FF, 1, 0, 0); tick();
      drive(32'h0001_0001, 1, 0, 1); tick();
      idle();
`ifdef VMX_DRAIN_SAT_EN
      exp5 = 48'h000102_FFFFFF;
`else
      exp5 = 48'h000102_000000;
`endif
      chk("lane_data", out_data, exp5);
      chk("lane_bcnt", beat_cnt, 8'hFF);
      chk("lane_err",  err,      2'b10);
      tick();

      // Restart mid-group, then reset mid-group
      drive(10, 0, 1, 0); tick();
      drive(20, 0, 0, 0); tick();
      drive(5,  0, 1, 0); tick();
      chk("restart_err", err, 2'b11);
      out_ready = 1'b0;
      drive(7, 0, 0, 1); tick();
      idle();
      chk("restart_data", out_data, 12);
      drive(50, 0, 1, 0); tick();
      idle();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst2_valid", out_valid, 0);
      chk("rst2_data",  out_data,  0);
      chk("rst2_err",   err,       0);
      chk("rst2_bcnt",  beat_cnt,  0);
      chk("rst2_ready", in_ready,  1);
      out_ready = 1'b1;
      drive(8, 0, 1, 1); tick();
      idle();
      chk("post_rst_data", out_data, 8);
      tick();

      // Beat without first in IDLE is dropped
      drive(99, 0, 0, 1); tick();
      idle();
      chk("stray_err",   err,       2'b01);
      chk("stray_valid", out_valid, 0);

      // Mode change mid-group: accumulated under latched SIMD mode
      drive(3, 1, 1, 0); tick();
      drive(4, 0, 0, 1); tick();
      idle();
      chk("mode_data", out_data, 7);
      chk("mode_simd", out_simd, 1);
      chk("mode_err",  err,      2'b01);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
